// File: rtl/ifft_pkg.sv
// ifft_pkg: shared constants, stage geometry and twiddle ROM for the 8-point SDF inverse FFT.
package ifft_pkg;
  localparam int DBW = 8;
  localparam int TBW = 6;
  localparam int FFT_N = 8;
  localparam int FFT_LOG2N = 3;
  localparam int CBW = FFT_LOG2N;
  localparam int STAGE_D [3] = '{4, 2, 1};
  localparam int STAGE_LAT [3] = '{0, 4, 6};
  // Conjugate twiddle W8^-k in Q1.(tbw-2): 1, (c+jc), j, (-c+jc)
  function automatic int tw(input int k, input int tbw, input bit im);
    int one, c;
    one = 1 << (tbw - 2);
    c = (7071 * one + 5000) / 10000;
    return im ? (k == 0 ? 0 : k == 2 ? one : c) : (k == 0 ? one : k == 1 ? c : k == 2 ? 0 : -c);
  endfunction
endpackage

// File: rtl/ifft_sdf_stage.sv
// ifft_sdf_stage: one radix-2 SDF stage with feedback delay D, halving butterfly and conjugate twiddle.
module ifft_sdf_stage import ifft_pkg::*; #(
  parameter int DBW = 8,
  parameter int TBW = 6,
  parameter int D = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               vin,
  input  logic [CBW-1:0]     idx,
  input  logic [2*DBW-1:0]   x,
  output logic               vout,
  output logic [2*DBW-1:0]   y
);
  localparam int LD = $clog2(D);
  localparam int K = FFT_N / (2 * D);
  localparam int PW = DBW + TBW + 2;
  localparam logic signed [TBW-1:0] WR [4] = '{TBW'(tw(0, TBW, 1'b0)), TBW'(tw(1, TBW, 1'b0)),
                                               TBW'(tw(2, TBW, 1'b0)), TBW'(tw(3, TBW, 1'b0))};
  localparam logic signed [TBW-1:0] WI [4] = '{TBW'(tw(0, TBW, 1'b1)), TBW'(tw(1, TBW, 1'b1)),
                                               TBW'(tw(2, TBW, 1'b1)), TBW'(tw(3, TBW, 1'b1))};
  logic [2*DBW-1:0] dl [D];
  logic [2*DBW-1:0] head, push, sum, dif;
  logic signed [DBW:0] ar, ai, br, bi, sr, si, dr, di;
  logic signed [PW-1:0] wr, wi, pr, pi;
  logic [1:0] tk;
  logic bf;
  // Second half of each 2D block: butterfly against the delayed first half
  always_comb begin
    head = dl[D-1];
    bf = idx[LD];
    tk = 2'((idx & CBW'(D - 1)) * CBW'(K));
    ar = {head[DBW-1], head[DBW-1:0]};
    ai = {head[2*DBW-1], head[2*DBW-1:DBW]};
    br = {x[DBW-1], x[DBW-1:0]};
    bi = {x[2*DBW-1], x[2*DBW-1:DBW]};
    sr = ar + br;
    si = ai + bi;
    dr = ar - br;
    di = ai - bi;
    wr = PW'(WR[tk]);
    wi = PW'(WI[tk]);
    pr = PW'(dr) * wr - PW'(di) * wi;
    pi = PW'(dr) * wi + PW'(di) * wr;
    sum = {DBW'(si >>> 1), DBW'(sr >>> 1)};
    dif = tk[0] ? {DBW'(pi >>> (TBW - 1)), DBW'(pr >>> (TBW - 1))}
        : tk[1] ? {DBW'(dr >>> 1), DBW'((-di) >>> 1)}
        : {DBW'(di >>> 1), DBW'(dr >>> 1)};
    push = bf ? dif : x;
    y = bf ? sum : head;
  end
  always_ff @(posedge clk)
    if (en) begin
      dl[0] <= push;
      for (int i = 1; i < D; i++) dl[i] <= dl[i-1];
    end
  always_ff @(posedge clk)
    if (rst) vout <= 1'b0;
    else if (en && vin && idx == CBW'(D - 1)) vout <= 1'b1;
endmodule

// File: rtl/ifft_8.sv
// ifft_8: 8-point streaming radix-2 SDF inverse FFT with built-in 1/N scaling.
// Define IFFT_REORDER_EN for natural-order output via a ping-pong buffer; otherwise bit-reversed order.
module ifft_8 import ifft_pkg::*; #(
  parameter int DBW = ifft_pkg::DBW,
  parameter int TBW = ifft_pkg::TBW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [2*DBW-1:0] din,
  output logic             dout_valid,
  output logic             dout_first,
  output logic [2*DBW-1:0] dout
);
  logic [CBW-1:0] cnt, i1, i2, i3, oi;
  logic en, srst, v1, v2, v3, ov;
  logic [2*DBW-1:0] y1, y2, y3, od;
  // Each stage sees the sample index of its own input stream
  always_comb begin
    en = in_valid & ~clear;
    srst = rst | clear;
    i1 = cnt - CBW'(STAGE_LAT[0]);
    i2 = cnt - CBW'(STAGE_LAT[1]);
    i3 = cnt - CBW'(STAGE_LAT[2]);
    oi = cnt + 1'b1;
  end
  ifft_sdf_stage #(.DBW(DBW), .TBW(TBW), .D(STAGE_D[0])) u_s1 (
    .clk(clk), .rst(srst), .en(en), .vin(1'b1), .idx(i1), .x(din), .vout(v1), .y(y1));
  ifft_sdf_stage #(.DBW(DBW), .TBW(TBW), .D(STAGE_D[1])) u_s2 (
    .clk(clk), .rst(srst), .en(en), .vin(v1), .idx(i2), .x(y1), .vout(v2), .y(y2));
  ifft_sdf_stage #(.DBW(DBW), .TBW(TBW), .D(STAGE_D[2])) u_s3 (
    .clk(clk), .rst(srst), .en(en), .vin(v2), .idx(i3), .x(y2), .vout(v3), .y(y3));
`ifdef IFFT_REORDER_EN
  logic [2*DBW-1:0] mem [2][FFT_N];
  logic [CBW-1:0] wa;
  logic bank, rv;
  // Fill one bank at bit-reversed address while the other drains in natural order
  always_comb begin
    wa = {oi[0], oi[1], oi[2]};
    ov = rv;
    od = mem[~bank][oi];
  end
  always_ff @(posedge clk)
    if (en && v3) mem[bank][wa] <= y3;
  always_ff @(posedge clk)
    if (srst) begin
      bank <= 1'b0;
      rv <= 1'b0;
    end else if (en && v3 && oi == CBW'(FFT_N - 1)) begin
      bank <= ~bank;
      rv <= 1'b1;
    end
`else
  always_comb begin
    ov = v3;
    od = y3;
  end
`endif
  always_ff @(posedge clk)
    if (srst) begin
      cnt <= '0;
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
      dout <= '0;
    end else begin
      if (in_valid) cnt <= cnt + 1'b1;
      dout_valid <= in_valid && ov;
      dout_first <= in_valid && ov && oi == '0;
      if (in_valid) dout <= od;
    end
endmodule
